hash_out_serializer: RTL and testbench

Streams a finished Blake2b digest out of the core one byte per cycle over the same 8-bit external data path used for input. The block sits between the hash core and the chip I/O, beside the input-side configuration/block-data logic. It captures the 512-bit final state when the core signals completion. It then emits the first nn bytes, byte 0 first, under a valid/ready handshake.

---
 rtl/hash_out_if.sv | 37 +++
 rtl/hash_out_serializer.sv | 111 +++++++++++
 tb/tb_hash_out_serializer.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hash_out_if.sv
// Digest output bus between the hash core side and the byte-wide I/O path.
// BLAKE2_OUT_LAST_EN adds the data_last_o end-of-digest marker.
interface hash_out_if #(
   parameter int unsigned H_W = 512
) ();
   logic            hash_v_i;
   logic [H_W-1:0]  h_i;
   logic [7:0]      nn_i;
   logic            ready_i;
   logic            busy_o;
   logic            data_v_o;
   logic [7:0]      data_o;
   logic [5:0]      data_idx_o;
   logic            done_o;
   logic            drop_o;
`ifdef BLAKE2_OUT_LAST_EN
   logic            data_last_o;
`endif

   modport slave (
      input  hash_v_i, h_i, nn_i, ready_i,
      output busy_o, data_v_o, data_o, data_idx_o, done_o,
`ifdef BLAKE2_OUT_LAST_EN
      output data_last_o,
`endif
      output drop_o
   );

   modport master (
      output hash_v_i, h_i, nn_i, ready_i,
      input  busy_o, data_v_o, data_o, data_idx_o, done_o,
`ifdef BLAKE2_OUT_LAST_EN
      input  data_last_o,
`endif
      input  drop_o
   );
endinterface

// File: rtl/hash_out_serializer.sv
// Captures the final Blake2b state and streams the first nn bytes, byte 0 first.
// BLAKE2_OUT_LAST_EN adds a registered last-byte flag on the output bus.
module hash_out_serializer #(
   parameter int unsigned NN_MAX = 64,
   parameter int unsigned H_W    = 512
) (
   input logic       clk,
   input logic       nreset,
   hash_out_if.slave bus
);
   // 7-bit index/length so a length of 64 compares without wrapping
   localparam int unsigned IDX_W = 7;

   typedef enum logic [1:0] {IDLE, SEND, DONE} state_e;

   state_e             state_q, state_d;
   logic [H_W-1:0]     sr_q, sr_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [IDX_W-1:0]   len_q, len_d;
   logic [IDX_W-1:0]   len_clamp_c;
   logic               busy_q, busy_d;
   logic               data_v_q, data_v_d;
   logic               done_q, done_d;
   logic               drop_q, drop_d;
`ifdef BLAKE2_OUT_LAST_EN
   logic               last_q, last_d;
`endif

   always_comb begin
      len_clamp_c = (bus.nn_i > 8'(NN_MAX)) ? IDX_W'(NN_MAX) : IDX_W'(bus.nn_i);
   end

   // next-state, datapath and registered-output decode
   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      idx_d   = idx_q;
      len_d   = len_q;
      drop_d  = drop_q;

      case (state_q)
         IDLE: begin
            if (bus.hash_v_i) begin
               sr_d    = bus.h_i;
               len_d   = len_clamp_c;
               idx_d   = '0;
               state_d = (len_clamp_c == '0) ? DONE : SEND;
            end
         end
         SEND: begin
            if (bus.hash_v_i) drop_d = 1'b1;
            if (bus.ready_i) begin
               sr_d  = sr_q >> 8;
               idx_d = IDX_W'(idx_q + IDX_W'(1));
               if (idx_q == IDX_W'(len_q - IDX_W'(1))) state_d = DONE;
            end
         end
         DONE: begin
            if (bus.hash_v_i) drop_d = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      busy_d   = (state_d != IDLE);
      data_v_d = (state_d == SEND);
      done_d   = (state_d == DONE);
`ifdef BLAKE2_OUT_LAST_EN
      last_d   = (state_d == SEND) && (idx_d == IDX_W'(len_d - IDX_W'(1)));
`endif
   end

   always_ff @(posedge clk) begin
      if (!nreset) begin
         state_q  <= IDLE;
         sr_q     <= '0;
         idx_q    <= '0;
         len_q    <= '0;
         busy_q   <= 1'b0;
         data_v_q <= 1'b0;
         done_q   <= 1'b0;
         drop_q   <= 1'b0;
`ifdef BLAKE2_OUT_LAST_EN
         last_q   <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         sr_q     <= sr_d;
         idx_q    <= idx_d;
         len_q    <= len_d;
         busy_q   <= busy_d;
         data_v_q <= data_v_d;
         done_q   <= done_d;
         drop_q   <= drop_d;
`ifdef BLAKE2_OUT_LAST_EN
         last_q   <= last_d;
`endif
      end
   end

   assign bus.busy_o     = busy_q;
   assign bus.data_v_o   = data_v_q;
   assign bus.data_o     = sr_q[7:0];
   assign bus.data_idx_o = idx_q[5:0];
   assign bus.done_o     = done_q;
   assign bus.drop_o     = drop_q;
`ifdef BLAKE2_OUT_LAST_EN
   assign bus.data_last_o = last_q;
`endif

endmodule

// File: tb/tb_hash_out_serializer.sv
// Randomized bench for hash_out_serializer against a byte-list model of the digest stream.
module tb_hash_out_serializer;
   localparam int unsigned NN_MAX = 64;
   localparam int unsigned H_W    = 512;

   logic clk    = 1'b0;
   logic nreset = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   hash_out_if #(.H_W(H_W)) bus ();

   hash_out_serializer #(.NN_MAX(NN_MAX), .H_W(H_W)) dut (
      .clk    (clk),
      .nreset (nreset),
      .bus    (bus)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [H_W-1:0] rand_hash();
      logic [H_W-1:0] h;
      for (int i = 0; i < H_W / 32; i++) h[32*i +: 32] = $urandom;
      return h;
   endfunction

   task automatic test_reset();
      bus.hash_v_i = 1'b0;
      bus.h_i      = '0;
      bus.nn_i     = '0;
      bus.ready_i  = 1'b0;
      nreset       = 1'b0;
      tick();
      tick();
      n_checks++;
      if (bus.data_v_o !== 1'b0 || bus.data_o !== 8'h00 || bus.data_idx_o !== 6'd0 ||
          bus.done_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.drop_o !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_values: got v=%b d=%h i=%0d done=%b busy=%b drop=%b required all zero",
                  bus.data_v_o, bus.data_o, bus.data_idx_o, bus.done_o, bus.busy_o, bus.drop_o);
      end
`ifdef BLAKE2_OUT_LAST_EN
      n_checks++;
      if (bus.data_last_o !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_last: got %b required 0", bus.data_last_o);
      end
`endif
      nreset = 1'b1;
      tick();
   endtask

   // mode 0: ready always high, 1: toggling 1/0, 2: random
   task automatic test_stream(input string name, input logic [H_W-1:0] h,
                              input logic [7:0] nn, input int mode);
      int         len;
      int         k;
      int         cyc;
      logic [7:0] eb;
      logic       rdy;
      len = (int'(nn) > NN_MAX) ? NN_MAX : int'(nn);
      bus.h_i      = h;
      bus.nn_i     = nn;
      bus.hash_v_i = 1'b1;
      bus.ready_i  = 1'b0;
      tick();
      bus.hash_v_i = 1'b0;
      bus.h_i      = ~h;
      bus.nn_i     = 8'($urandom_range(0, 255));
      k   = 0;
      cyc = 0;
      while (k < len && cyc < 1000) begin
         eb = h[8*k +: 8];
         n_checks++;
         if (bus.data_v_o !== 1'b1 || bus.data_o !== eb || bus.data_idx_o !== 6'(k) ||
             bus.done_o !== 1'b0 || bus.busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_byte: got v=%b d=%h i=%0d done=%b busy=%b required v=1 d=%h i=%0d done=0 busy=1",
                     name, bus.data_v_o, bus.data_o, bus.data_idx_o, bus.done_o, bus.busy_o, eb, k);
         end
`ifdef BLAKE2_OUT_LAST_EN
         n_checks++;
         if (bus.data_last_o !== (k == len - 1)) begin
            n_fail++;
            $display("FAIL %s_last: idx %0d got %b required %b", name, k, bus.data_last_o, (k == len - 1));
         end
`endif
         case (mode)
            0:       rdy = 1'b1;
            1:       rdy = (cyc % 2 == 0);
            default: rdy = 1'($urandom_range(0, 1));
         endcase
         bus.ready_i = rdy;
         tick();
         cyc++;
         if (rdy) k++;
      end
      n_checks++;
      if (cyc >= 1000) begin
         n_fail++;
         $display("FAIL %s_timeout: got %0d bytes required %0d", name, k, len);
      end
      n_checks++;
      if (bus.done_o !== 1'b1 || bus.data_v_o !== 1'b0 || bus.busy_o !== 1'b1) begin
         n_fail++;
         $display("FAIL %s_done: got done=%b v=%b busy=%b required done=1 v=0 busy=1",
                  name, bus.done_o, bus.data_v_o, bus.busy_o);
      end
      bus.ready_i = 1'b0;
      tick();
      n_checks++;
      if (bus.done_o !== 1'b0 || bus.data_v_o !== 1'b0 || bus.busy_o !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_idle: got done=%b v=%b busy=%b required all 0",
                  name, bus.done_o, bus.data_v_o, bus.busy_o);
      end
   endtask

   task automatic test_zero();
      bus.h_i      = rand_hash();
      bus.nn_i     = 8'd0;
      bus.hash_v_i = 1'b1;
      bus.ready_i  = 1'b1;
      tick();
      bus.hash_v_i = 1'b0;
      n_checks++;
      if (bus.done_o !== 1'b1 || bus.data_v_o !== 1'b0 || bus.busy_o !== 1'b1) begin
         n_fail++;
         $display("FAIL zero_done: got done=%b v=%b busy=%b required done=1 v=0 busy=1",
                  bus.done_o, bus.data_v_o, bus.busy_o);
      end
      tick();
      n_checks++;
      if (bus.done_o !== 1'b0 || bus.data_v_o !== 1'b0 || bus.busy_o !== 1'b0) begin
         n_fail++;
         $display("FAIL zero_idle: got done=%b v=%b busy=%b required all 0",
                  bus.done_o, bus.data_v_o, bus.busy_o);
      end
   endtask

   task automatic test_collision();
      logic [H_W-1:0] h;
      logic [7:0]     eb;
      n_checks++;
      if (bus.drop_o !== 1'b0) begin
         n_fail++;
         $display("FAIL coll_pre_drop: got %b required 0", bus.drop_o);
      end
      h = rand_hash();
      bus.h_i      = h;
      bus.nn_i     = 8'd64;
      bus.hash_v_i = 1'b1;
      bus.ready_i  = 1'b1;
      tick();
      for (int k = 0; k < 64; k++) begin
         eb = h[8*k +: 8];
         n_checks++;
         if (bus.data_v_o !== 1'b1 || bus.data_o !== eb || bus.data_idx_o !== 6'(k)) begin
            n_fail++;
            $display("FAIL coll_byte: got v=%b d=%h i=%0d required v=1 d=%h i=%0d",
                     bus.data_v_o, bus.data_o, bus.data_idx_o, eb, k);
         end
         bus.hash_v_i = (k == 10);
         bus.h_i      = (k == 10) ? ~h : h;
         bus.nn_i     = (k == 10) ? 8'd5 : 8'd64;
         tick();
      end
      bus.hash_v_i = 1'b0;
      n_checks++;
      if (bus.done_o !== 1'b1 || bus.drop_o !== 1'b1) begin
         n_fail++;
         $display("FAIL coll_done: got done=%b drop=%b required done=1 drop=1", bus.done_o, bus.drop_o);
      end
      tick();
      tick();
      n_checks++;
      if (bus.drop_o !== 1'b1 || bus.busy_o !== 1'b0) begin
         n_fail++;
         $display("FAIL coll_sticky: got drop=%b busy=%b required drop=1 busy=0", bus.drop_o, bus.busy_o);
      end
   endtask

   task automatic test_reset_mid();
      logic [H_W-1:0] h;
      h = rand_hash();
      bus.h_i      = h;
      bus.nn_i     = 8'd64;
      bus.hash_v_i = 1'b1;
      bus.ready_i  = 1'b1;
      tick();
      bus.hash_v_i = 1'b0;
      for (int k = 0; k < 5; k++) tick();
      n_checks++;
      if (bus.data_v_o !== 1'b1 || bus.data_idx_o !== 6'd5 || bus.data_o !== h[47:40]) begin
         n_fail++;
         $display("FAIL rmid_byte5: got v=%b i=%0d d=%h required v=1 i=5 d=%h",
                  bus.data_v_o, bus.data_idx_o, bus.data_o, h[47:40]);
      end
      nreset = 1'b0;
      tick();
      n_checks++;
      if (bus.data_v_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.done_o !== 1'b0 ||
          bus.drop_o !== 1'b0 || bus.data_idx_o !== 6'd0 || bus.data_o !== 8'h00) begin
         n_fail++;
         $display("FAIL rmid_reset: got v=%b busy=%b done=%b drop=%b i=%0d d=%h required all 0",
                  bus.data_v_o, bus.busy_o, bus.done_o, bus.drop_o, bus.data_idx_o, bus.data_o);
      end
      nreset = 1'b1;
      tick();
      n_checks++;
      if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b0) begin
         n_fail++;
         $display("FAIL rmid_nodone: got done=%b busy=%b required 0 0", bus.done_o, bus.busy_o);
      end
      test_stream("rmid_restart", rand_hash(), 8'd16, 2);
   endtask

   initial begin
      logic [H_W-1:0] hseq;
      for (int k = 0; k < 64; k++) hseq[8*k +: 8] = 8'(k);
      test_reset();
      test_stream("full", hseq, 8'd64, 0);
      test_stream("short_bp", rand_hash(), 8'd32, 1);
      test_stream("clamp", rand_hash(), 8'd200, 2);
      test_stream("last20", rand_hash(), 8'd20, 1);
      test_stream("one", rand_hash(), 8'd1, 1);
      for (int i = 0; i < 4; i++)
         test_stream("rand", rand_hash(), 8'($urandom_range(1, 70)), 2);
      test_zero();
      test_stream("after_zero", rand_hash(), 8'd3, 0);
      test_collision();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
